// File: rtl/cpu_multicycle_core.sv
// cpu_multicycle_core
//   Multi-cycle CPU core. Each instruction takes one FETCH cycle, plus one
//   cycle per cycle of imem_busywait, and then exactly one EXEC cycle.
//   The core contains the PC sequencer, a FETCH/EXEC control FSM, the
//   register file, the ALU and a two's-complement subtract path.
//
// Ports
//   CLK            clock; all state updates on posedge
//   RESET          synchronous, active-high reset
//   PC             registered fetch address
//   INSTRUCTION    instruction word from imem
//   imem_read      fetch request (FETCH state, not in reset)
//   imem_busywait  imem not ready; 0 = INSTRUCTION valid this cycle
//   retire         high for the single EXEC cycle of every instruction
//   illegal        high in EXEC when the opcode is undefined
//   dbg_addr       debug register select
//   dbg_data       combinational read of regs[dbg_addr]
//
// Fetch handshake: imem_read is the request and ~imem_busywait is the
// response. INSTRUCTION is captured on the first posedge in FETCH where
// busywait is 0. In every other cycle INSTRUCTION is ignored.
module cpu_multicycle_core #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int PC_W       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [PC_W-1:0]       PC,
  input  logic [31:0]           INSTRUCTION,
  output logic                  imem_read,
  input  logic                  imem_busywait,
  output logic                  retire,
  output logic                  illegal,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int NREG = 1 << REG_ADDR_W;
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);
  localparam logic [PC_W-1:0]   FOUR  = PC_W'(4);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t state;
  state_t state_next;

  logic [31:0]           ir;
  logic [DATA_W-1:0]     regs [NREG];

  // Instruction fields
  logic [7:0]            op;
  logic [REG_ADDR_W-1:0] dest;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     imm_ext;
  logic [PC_W-1:0]       off_ext;
  logic [PC_W-1:0]       pc_plus4;
  logic [PC_W-1:0]       target;

  // Results of decode
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  taken;
  logic                  bad_op;

  // Bits 15:11 of the instruction carry no field.
  logic                  unused_ir;
  assign unused_ir = ^ir[15:8];

  assign op       = ir[31:24];
  assign dest     = ir[16 +: REG_ADDR_W];
  assign src1     = ir[8 +: REG_ADDR_W];
  assign src2     = ir[0 +: REG_ADDR_W];
  assign op_a     = regs[src1];
  assign op_b     = regs[src2];
  assign imm_ext  = DATA_W'($signed(ir[7:0]));
  assign off_ext  = PC_W'($signed(ir[23:16]));
  assign pc_plus4 = PC + FOUR;
  // The offset is a word offset that is relative to the next PC.
  // The result wraps modulo 2**PC_W.
  assign target   = pc_plus4 + (off_ext << 2);

  assign dbg_data = regs[dbg_addr];

  // Decode and ALU
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    taken   = 1'b0;
    bad_op  = 1'b0;
    case (op)
      8'h00: begin wr_en = 1'b1; wr_data = imm_ext;              end
      8'h01: begin wr_en = 1'b1; wr_data = op_b;                 end
      8'h02: begin wr_en = 1'b1; wr_data = op_a + op_b;          end
      8'h03: begin wr_en = 1'b1; wr_data = op_a + (~op_b + ONE); end
      8'h04: begin wr_en = 1'b1; wr_data = op_a & op_b;          end
      8'h05: begin wr_en = 1'b1; wr_data = op_a | op_b;          end
      8'h06: taken = 1'b1;
      8'h07: taken = (op_a == op_b);
      default: bad_op = 1'b1;
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= FETCH;
    else       state <= state_next;
  end

  // FSM next state and outputs
  always_comb begin
    state_next = state;
    imem_read  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        imem_read = ~RESET;
        if (!imem_busywait) state_next = EXEC;
      end
      EXEC: begin
        retire     = ~RESET;
        illegal    = ~RESET & bad_op;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Datapath state. RESET has priority, so a pending EXEC update is dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      PC <= '0;
      ir <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (state == FETCH && !imem_busywait) ir <= INSTRUCTION;
      if (state == EXEC) begin
        PC <= taken ? target : pc_plus4;
        if (wr_en) regs[dest] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_core.sv
module tb_cpu_multicycle_core;

  logic        CLK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic        imem_busywait;
  logic [2:0]  dbg_addr;

  logic [31:0] pc8, pc16;
  logic        rd8, rd16, ret8, ret16, ill8, ill16;
  logic [7:0]  dd8;
  logic [15:0] dd16;

  int checks   = 0;
  int failures = 0;
  int ret_cnt;

  // Both cores see the same stimulus. The 16-bit core is checked only where
  // the data width matters.
  cpu_multicycle_core #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(32)) dut8 (
    .CLK(CLK), .RESET(RESET), .PC(pc8), .INSTRUCTION(INSTRUCTION),
    .imem_read(rd8), .imem_busywait(imem_busywait), .retire(ret8),
    .illegal(ill8), .dbg_addr(dbg_addr), .dbg_data(dd8)
  );

  cpu_multicycle_core #(.DATA_W(16), .REG_ADDR_W(3), .PC_W(32)) dut16 (
    .CLK(CLK), .RESET(RESET), .PC(pc16), .INSTRUCTION(INSTRUCTION),
    .imem_read(rd16), .imem_busywait(imem_busywait), .retire(ret16),
    .illegal(ill16), .dbg_addr(dbg_addr), .dbg_data(dd16)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  always @(posedge CLK) begin
    if (RESET)     ret_cnt <= 0;
    else if (ret8) ret_cnt <= ret_cnt + 1;
  end

  // Encoders
  function automatic logic [31:0] mki(input logic [2:0] d, input logic [7:0] imm);
    return {8'h00, 5'b0, d, 8'h00, imm};
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [2:0] d,
                                     input logic [2:0] s1, input logic [2:0] s2);
    return {op, 5'b0, d, 5'b0, s1, 5'b0, s2};
  endfunction

  function automatic logic [31:0] mkb(input logic [7:0] op, input logic [7:0] off,
                                      input logic [2:0] s1, input logic [2:0] s2);
    return {op, off, 5'b0, s1, 5'b0, s2};
  endfunction

  // Checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg8(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {56'h0, dd8}, {56'h0, exp});
  endtask

  task automatic chk_reg16(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {48'h0, dd16}, {48'h0, exp});
  endtask

  // Drivers. Every driver starts and ends at a negedge.
  // issue: the core is in FETCH at entry and in EXEC at return.
  task automatic issue(input logic [31:0] instr);
    imem_busywait = 1'b0;
    INSTRUCTION   = instr;
    @(posedge CLK);
    @(negedge CLK);
    INSTRUCTION   = $urandom;
    imem_busywait = 1'($urandom_range(0, 1));
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
    imem_busywait = 1'b0;
  endtask

  task automatic run(input logic [31:0] instr);
    issue(instr);
    next_cycle();
  endtask

  task automatic do_reset();
    RESET         = 1'b1;
    imem_busywait = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET         = 1'b1;
    INSTRUCTION   = 32'h0;
    imem_busywait = 1'b0;
    dbg_addr      = 3'd0;
    @(negedge CLK);
    @(negedge CLK);

    // Reset state
    chk("rst_pc", {32'h0, pc8}, 64'h0);
    chk("rst_imem_read", {63'h0, rd8}, 64'h0);
    chk("rst_retire", {63'h0, ret8}, 64'h0);
    chk("rst_illegal", {63'h0, ill8}, 64'h0);
    chk_reg8("rst_r1", 3'd1, 8'h00);
    chk_reg16("rst_r1_16", 3'd1, 16'h0000);
    RESET = 1'b0;
    #1;

    // Test 1: loadi and sub
    chk("fetch_imem_read", {63'h0, rd8}, 64'h1);
    run(mki(3'd1, 8'h05));
    chk_reg8("loadi_r1", 3'd1, 8'h05);
    run(mki(3'd2, 8'h03));
    run(mk(8'h03, 3'd3, 3'd1, 3'd2));
    chk_reg8("sub_r3", 3'd3, 8'h02);
    chk("t1_pc", {32'h0, pc8}, 64'h0C);
    chk("t1_retires", 64'(ret_cnt), 64'd3);

    // Test 2: add overflow, negative sub, and, or, dest==src
    run(mki(3'd1, 8'h7F));
    run(mki(3'd2, 8'h01));
    run(mk(8'h02, 3'd4, 3'd1, 3'd2));
    chk_reg8("add_r4", 3'd4, 8'h80);
    run(mk(8'h03, 3'd5, 3'd2, 3'd1));
    chk_reg8("sub_r5", 3'd5, 8'h82);
    run(mk(8'h04, 3'd6, 3'd4, 3'd5));
    chk_reg8("and_r6", 3'd6, 8'h80);
    run(mk(8'h05, 3'd7, 3'd4, 3'd2));
    chk_reg8("or_r7", 3'd7, 8'h81);
    issue(mk(8'h02, 3'd1, 3'd1, 3'd1));
    chk_reg8("self_add_old", 3'd1, 8'h7F);
    chk("exec_retire", {63'h0, ret8}, 64'h1);
    chk("exec_illegal", {63'h0, ill8}, 64'h0);
    chk("exec_imem_read", {63'h0, rd8}, 64'h0);
    next_cycle();
    chk_reg8("self_add_new", 3'd1, 8'hFE);
    chk("t2_pc", {32'h0, pc8}, 64'h28);

    // Test 3: busywait held for 3 cycles on the first fetch
    do_reset();
    for (int i = 0; i < 3; i++) begin
      imem_busywait = 1'b1;
      INSTRUCTION   = mki(3'd6, 8'h11);
      @(posedge CLK);
      @(negedge CLK);
      chk("wait_pc", {32'h0, pc8}, 64'h0);
      chk("wait_imem_read", {63'h0, rd8}, 64'h1);
      chk("wait_retire", {63'h0, ret8}, 64'h0);
    end
    issue(mki(3'd6, 8'h80));
    chk("wait_exec_retire", {63'h0, ret8}, 64'h1);
    next_cycle();
    chk_reg8("wait_r6", 3'd6, 8'h80);
    chk("t3_pc", {32'h0, pc8}, 64'h04);

    // Test 4: beq taken and not taken, then j
    run(mki(3'd1, 8'h09));
    run(mki(3'd2, 8'h09));
    run(mki(3'd3, 8'h01));
    chk("pre_beq_pc", {32'h0, pc8}, 64'h10);
    run(mkb(8'h07, 8'hFE, 3'd1, 3'd2));
    chk("beq_taken_pc", {32'h0, pc8}, 64'h0C);
    chk_reg8("beq_no_write", 3'd6, 8'h80);
    run(mki(3'd4, 8'h00));
    run(mkb(8'h07, 8'hFE, 3'd1, 3'd3));
    chk("beq_not_taken_pc", {32'h0, pc8}, 64'h14);
    run(mkb(8'h06, 8'hFE, 3'd0, 3'd0));
    chk("j_back_pc", {32'h0, pc8}, 64'h10);
    run(mkb(8'h06, 8'h02, 3'd0, 3'd0));
    chk("j_fwd_pc", {32'h0, pc8}, 64'h1C);

    // Test 5: illegal opcodes, then reset during EXEC
    issue(32'hFF01_0105);
    chk("ill_flag", {63'h0, ill8}, 64'h1);
    chk("ill_retire", {63'h0, ret8}, 64'h1);
    next_cycle();
    chk("ill_clear", {63'h0, ill8}, 64'h0);
    chk_reg8("ill_no_write", 3'd1, 8'h09);
    chk("ill_pc", {32'h0, pc8}, 64'h20);
    run(32'h0801_0000);
    chk_reg8("ill08_no_write", 3'd1, 8'h09);
    chk("ill08_pc", {32'h0, pc8}, 64'h24);
    issue(mki(3'd7, 8'h55));
    RESET         = 1'b1;
    imem_busywait = 1'b0;
    #1;
    chk("rst_exec_retire", {63'h0, ret8}, 64'h0);
    @(posedge CLK);
    @(negedge CLK);
    chk_reg8("rst_drop_r7", 3'd7, 8'h00);
    chk_reg8("rst_clear_r1", 3'd1, 8'h00);
    chk("rst_exec_pc", {32'h0, pc8}, 64'h0);
    chk("rst_exec_imem_read", {63'h0, rd8}, 64'h0);
    RESET = 1'b0;
    #1;

    // Test 6: 16-bit sign extension and PC wrap
    run(mki(3'd1, 8'h80));
    chk_reg16("sext16_r1", 3'd1, 16'hFF80);
    chk_reg8("sext8_r1", 3'd1, 8'h80);
    run(mkb(8'h06, 8'hFD, 3'd0, 3'd0));
    chk("wrap_back_pc16", {32'h0, pc16}, 64'hFFFF_FFFC);
    chk("wrap_back_pc8", {32'h0, pc8}, 64'hFFFF_FFFC);
    run(mk(8'h01, 3'd2, 3'd0, 3'd1));
    chk("wrap_fwd_pc16", {32'h0, pc16}, 64'h0);
    chk_reg16("mov16_r2", 3'd2, 16'hFF80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
